// File: rtl/regfile_wb_arbiter.sv
// rtl/regfile_wb_arbiter.sv - round-robin write-back arbiter for the register file write port
// Two small FIFOs (A = ALU, M = load) share one registered write port; hazard covers queued and in-flight writes.
module regfile_wb_arbiter #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5,
   parameter int DEPTH  = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              a_valid,
   input  logic [ADDR_W-1:0] a_reg,
   input  logic [DATA_W-1:0] a_data,
   output logic              a_ready,
   input  logic              m_valid,
   input  logic [ADDR_W-1:0] m_reg,
   input  logic [DATA_W-1:0] m_data,
   output logic              m_ready,
   input  logic [ADDR_W-1:0] chk_reg1,
   input  logic [ADDR_W-1:0] chk_reg2,
   output logic              hazard,
   output logic [DATA_W-1:0] write_data,
   output logic [ADDR_W-1:0] write_reg,
   output logic              regwrite,
   output logic              idle
);
   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int ENT_W = ADDR_W + DATA_W;

   logic [ENT_W-1:0]  mem_q    [2][DEPTH];
   logic [DEPTH-1:0]  vld_q    [2];
   logic [DEPTH-1:0]  vld_d    [2];
   logic [PTR_W-1:0]  wr_ptr_q [2];
   logic [PTR_W-1:0]  wr_ptr_d [2];
   logic [PTR_W-1:0]  rd_ptr_q [2];
   logic [PTR_W-1:0]  rd_ptr_d [2];
   logic [ENT_W-1:0]  push_ent [2];
   logic [ENT_W-1:0]  head_ent [2];
   logic [1:0]        full;
   logic [1:0]        head_vld;
   logic [1:0]        push;
   logic [1:0]        pop;
   logic              rr_q, rr_d;
   logic              regwrite_q, regwrite_d;
   logic [ADDR_W-1:0] write_reg_q, write_reg_d;
   logic [DATA_W-1:0] write_data_q, write_data_d;

   assign push_ent[0] = {a_reg, a_data};
   assign push_ent[1] = {m_reg, m_data};

   // Per-slot valid bits: the slot under wr_ptr being occupied means full.
   always_comb begin
      for (int s = 0; s < 2; s++) begin
         full[s]     = vld_q[s][wr_ptr_q[s]];
         head_vld[s] = vld_q[s][rd_ptr_q[s]];
         head_ent[s] = mem_q[s][rd_ptr_q[s]];
      end
   end

   assign a_ready = !full[0] && !rst;
   assign m_ready = !full[1] && !rst;
   assign push    = {m_valid && m_ready, a_valid && a_ready};

   always_comb begin
      pop = head_vld;
      if (&head_vld) begin
         pop = rr_q ? 2'b10 : 2'b01;
      end
      rr_d = rr_q;
      if (pop[0]) begin
         rr_d = 1'b1;
      end else if (pop[1]) begin
         rr_d = 1'b0;
      end
      regwrite_d   = |pop;
      write_reg_d  = write_reg_q;
      write_data_d = write_data_q;
      if (pop[0]) begin
         {write_reg_d, write_data_d} = head_ent[0];
      end else if (pop[1]) begin
         {write_reg_d, write_data_d} = head_ent[1];
      end
   end

   always_comb begin
      for (int s = 0; s < 2; s++) begin
         vld_d[s]    = vld_q[s];
         wr_ptr_d[s] = wr_ptr_q[s];
         rd_ptr_d[s] = rd_ptr_q[s];
         if (push[s]) begin
            vld_d[s][wr_ptr_q[s]] = 1'b1;
            wr_ptr_d[s]           = wr_ptr_q[s] + 1'b1;
         end
         if (pop[s]) begin
            vld_d[s][rd_ptr_q[s]] = 1'b0;
            rd_ptr_d[s]           = rd_ptr_q[s] + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int s = 0; s < 2; s++) begin
            vld_q[s]    <= '0;
            wr_ptr_q[s] <= '0;
            rd_ptr_q[s] <= '0;
         end
         rr_q         <= 1'b0;
         regwrite_q   <= 1'b0;
         write_reg_q  <= '0;
         write_data_q <= '0;
      end else begin
         for (int s = 0; s < 2; s++) begin
            vld_q[s]    <= vld_d[s];
            wr_ptr_q[s] <= wr_ptr_d[s];
            rd_ptr_q[s] <= rd_ptr_d[s];
         end
         rr_q         <= rr_d;
         regwrite_q   <= regwrite_d;
         write_reg_q  <= write_reg_d;
         write_data_q <= write_data_d;
      end
   end

   // Payload needs no reset; only slots flagged in vld_q are ever read.
   always_ff @(posedge clk) begin
      for (int s = 0; s < 2; s++) begin
         if (push[s]) begin
            mem_q[s][wr_ptr_q[s]] <= push_ent[s];
         end
      end
   end

   always_comb begin
      hazard = regwrite_q && ((write_reg_q == chk_reg1) || (write_reg_q == chk_reg2));
      for (int s = 0; s < 2; s++) begin
         for (int i = 0; i < DEPTH; i++) begin
            if (vld_q[s][i] && ((mem_q[s][i][ENT_W-1 -: ADDR_W] == chk_reg1) ||
                                (mem_q[s][i][ENT_W-1 -: ADDR_W] == chk_reg2))) begin
               hazard = 1'b1;
            end
         end
      end
   end

   assign idle       = !(|vld_q[0]) && !(|vld_q[1]) && !regwrite_q;
   assign regwrite   = regwrite_q;
   assign write_reg  = write_reg_q;
   assign write_data = write_data_q;

endmodule
